io_bank_arbiter: RTL and testbench
==================================

# io_bank_arbiter

Two-requester arbiter and access sequencer in front of the memory-mapped output bank (LEDs, 7-segment, LCD registers at 0x7000–0x703F). Requester 0 is the pipeline LSU and requester 1 is the auxiliary master (debug/boot loader). The block arbitrates, checks range and alignment, drives the bank for exactly one cycle per access, and returns a registered response. It sits in the MA stage between the LSU/aux ports and the output bank.

## Interface
- BASE_ADDR, 32'h0000_7000, bank window base; the window is 64 bytes, matched on addr[31:6].
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high.
- i_req  in  2  per-requester request; level-held until the matching o_gnt.
- i_wren  in  2  per-requester write (1) / read (0).
- i_addr  in  2x32  per-requester byte address.
- i_wdata  in  2x32  per-requester store data.
- i_funct3  in  2x3  per-requester RISC-V load/store funct3.
- o_gnt  out  2  one-hot, one-cycle accept pulse.
- o_rsp_valid  out  2  one-hot, one-cycle response pulse.
- o_rsp_err  out  1  response error flag, qualified by o_rsp_valid.
- o_rdata  out  32  load data, qualified by o_rsp_valid.
- o_bank_wren, o_bank_rden, o_bank_buf_en  out  1 each  bank strobes.
- o_bank_addr  out  32  bank address.
- o_bank_st_data  out  32  bank store data.
- o_bank_funct3  out  3  bank funct3.
- i_bank_ld_data  in  32  combinational bank load data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **Arbitration.** Arbitration happens in IDLE and RESP, and only when at least one request is asserted.
  - The winner receives o_gnt, which is Mealy (combinational from i_req and state).
  - On the grant edge, the winner's wren/addr/wdata/funct3 are latched into cmd registers, together with the owner index and a legal flag. The FSM then moves to ACCESS.
  - With no request, IDLE stays in IDLE and RESP returns to IDLE.
- **Legal flag.** legal = (addr[31:6]==BASE_ADDR[31:6]) and alignment is correct. Alignment rules:
  - byte funct3 0/4: any address;
  - half funct3 1/5: addr[0]==0;
  - word funct3 2: addr[1:0]==0.
  - funct3 3/6/7 are illegal. Stores accept only funct3 0/1/2.
- **ACCESS** (always exactly one cycle):
  - o_bank_* are driven from the cmd registers.
  - o_bank_buf_en = legal; o_bank_wren = legal & wren; o_bank_rden = legal & ~wren.
  - At the closing edge, rdata_q is loaded with i_bank_ld_data for a legal read, and with 0 otherwise. The FSM then moves to RESP.
- **RESP:**
  - o_rsp_valid[owner] = 1, o_rdata = rdata_q, o_rsp_err = ~legal.
  - A new grant may issue in the same cycle.
- **Bank strobes outside ACCESS:** all o_bank_* are 0. o_bank_addr/st_data/funct3 hold the cmd registers, but the strobes are 0.
- **Simultaneous requests:** arbitration policy per Configuration. A request deasserted before its grant is dropped silently.
- **Reset values:**
  - all outputs 0;
  - cmd registers and rdata_q 0;
  - round-robin pointer = 1 (requester 0 favoured first).
- **Reset mid-operation:** an access in progress is discarded and no response is produced. A write whose ACCESS cycle had not completed is not performed.

## Timing
- Grant in cycle T, bank access in T+1, response in T+2.
- Sustained throughput: one access per 2 cycles (grant overlaps RESP).
- Load-data path: i_bank_ld_data is sampled only at the end of ACCESS; o_rdata is fully registered.
- o_gnt is the only combinational output from the i_req inputs.

## Configuration
- IO_ARB_RR_EN defined: round-robin policy.
  - On contention the requester not granted last wins.
  - The pointer updates on every grant.
- IO_ARB_RR_EN undefined: fixed priority, requester 0 (LSU) always wins; the pointer register is absent.

## Structure
- Package io_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the IO_WIN_BITS = 6 constant.
- Sub-module io_rr_pick:
  - 2-input pick logic (req, last pointer) → one-hot grant;
  - compile-time switch between round-robin and fixed priority via IO_ARB_RR_EN.
- The legality check is a function in io_arb_pkg.

## Test plan
- **Single write then read.** Req0 SW 0x7000 data 0xA5A5_1234; then LW 0x7000 with the bank model returning stored data.
  - Expected: gnt at T, o_bank_wren in T+1 only, rsp at T+2 with err=0; read returns 0xA5A5_1234.
- **Contention.** Both requesters hold LW 0x7010 continuously.
  - With IO_ARB_RR_EN: grants alternate 0,1,0,1 every 2 cycles.
  - Without IO_ARB_RR_EN: requester 0 only; requester 1 starves.
- **Misaligned and out-of-range.** Req1 LH 0x7011, then SW 0x8000.
  - Expected: each gets rsp with err=1 and rdata=0; o_bank_buf_en/wren/rden stay 0 throughout.
- **Back-to-back.** Req0 held for 3 SB writes to 0x7020/0x7021/0x7022.
  - Expected: grants at T, T+2, T+4; bank write strobes at T+1, T+3, T+5.
- **Reset mid-access.** Assert i_rst in the ACCESS cycle of SW 0x7030.
  - Expected: all outputs 0 immediately, no rsp_valid; after release, the first contention grant goes to requester 0.
- **Sign extension passthrough.** Bank model returns 0xFFFF_FF80 for LB 0x7003.
  - Expected: o_rdata = 0xFFFF_FF80 registered at RESP; o_rsp_err = 0.

Source files
------------

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared FSM state type, RISC-V funct3 codes and the bank access
// legality rule used by io_bank_arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  localparam int IO_WIN_BITS = 6;

  // Legal = inside the 64-byte window and naturally aligned for the access size;
  // stores only exist as byte/half/word.
  function automatic logic io_access_legal(
    input logic [31-IO_WIN_BITS:0] addr_hi,
    input logic [31-IO_WIN_BITS:0] base_hi,
    input logic [1:0]              addr_lo,
    input logic                    wren,
    input logic [2:0]              funct3
  );
    logic in_win;
    logic aligned;
    in_win = (addr_hi == base_hi);
    case (funct3)
      LB, LBU: aligned = 1'b1;
      LH, LHU: aligned = ~addr_lo[0];
      LW:      aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
    if (wren && !(funct3 inside {SB, SH, SW})) begin
      aligned = 1'b0;
    end
    return in_win & aligned;
  endfunction

endpackage

// File: rtl/io_rr_pick.sv
// io_rr_pick: two-way request picker producing a one-hot grant.
// IO_ARB_RR_EN defined: round-robin on the last winner; undefined: requester 0 always wins.
module io_rr_pick (
  input  logic [1:0] req,
`ifdef IO_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    gnt = 2'b00;
    if (req == 2'b11) begin
`ifdef IO_ARB_RR_EN
      gnt = last ? 2'b01 : 2'b10;
`else
      gnt = 2'b01;
`endif
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/io_bank_arbiter.sv
// io_bank_arbiter: arbitrates the LSU (0) and aux master (1) onto the output bank,
// one single-cycle bank access per grant. Define IO_ARB_RR_EN for round-robin.
module io_bank_arbiter
  import io_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_wren,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  input  logic [5:0]  i_funct3,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rdata,
  output logic        o_bank_wren,
  output logic        o_bank_rden,
  output logic        o_bank_buf_en,
  output logic [31:0] o_bank_addr,
  output logic [31:0] o_bank_st_data,
  output logic [2:0]  o_bank_funct3,
  input  logic [31:0] i_bank_ld_data
);

  state_e      state;
  logic        cmd_wren;
  logic        cmd_owner;
  logic        cmd_legal;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_funct3;
  logic [31:0] rdata_q;

  logic [1:0]  pick_gnt;
  logic        win;
  logic        win_wren;
  logic        win_legal;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [2:0]  win_funct3;

`ifdef IO_ARB_RR_EN
  logic        rr_last;

  io_rr_pick u_pick (
    .req  (i_req),
    .last (rr_last),
    .gnt  (pick_gnt)
  );
`else
  io_rr_pick u_pick (
    .req  (i_req),
    .gnt  (pick_gnt)
  );
`endif

  // Grants are only offered while the bank is free; held low during reset.
  assign o_gnt = (!i_rst && state != ACCESS) ? pick_gnt : 2'b00;

  assign win        = o_gnt[1];
  assign win_wren   = win ? i_wren[1]        : i_wren[0];
  assign win_addr   = win ? i_addr[63:32]    : i_addr[31:0];
  assign win_wdata  = win ? i_wdata[63:32]   : i_wdata[31:0];
  assign win_funct3 = win ? i_funct3[5:3]    : i_funct3[2:0];
  assign win_legal  = io_access_legal(win_addr[31:IO_WIN_BITS], BASE_ADDR[31:IO_WIN_BITS],
                                      win_addr[1:0], win_wren, win_funct3);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cmd_wren      <= 1'b0;
      cmd_owner     <= 1'b0;
      cmd_legal     <= 1'b0;
      cmd_addr      <= 32'h0;
      cmd_wdata     <= 32'h0;
      cmd_funct3    <= 3'h0;
      rdata_q       <= 32'h0;
      o_rsp_valid   <= 2'b00;
      o_rsp_err     <= 1'b0;
      o_bank_wren   <= 1'b0;
      o_bank_rden   <= 1'b0;
      o_bank_buf_en <= 1'b0;
`ifdef IO_ARB_RR_EN
      rr_last       <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking everywhere here so every register samples pre-edge values.
      o_rsp_valid   <= 2'b00;
      o_rsp_err     <= 1'b0;
      o_bank_wren   <= 1'b0;
      o_bank_rden   <= 1'b0;
      o_bank_buf_en <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (|o_gnt) begin
            cmd_wren      <= win_wren;
            cmd_owner     <= win;
            cmd_legal     <= win_legal;
            cmd_addr      <= win_addr;
            cmd_wdata     <= win_wdata;
            cmd_funct3    <= win_funct3;
            o_bank_buf_en <= win_legal;
            o_bank_wren   <= win_legal & win_wren;
            o_bank_rden   <= win_legal & ~win_wren;
`ifdef IO_ARB_RR_EN
            rr_last       <= win;
`endif
            state         <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // Bank load data is combinational; capture it only for a legal read.
          rdata_q     <= (cmd_legal && !cmd_wren) ? i_bank_ld_data : 32'h0;
          o_rsp_valid <= cmd_owner ? 2'b10 : 2'b01;
          o_rsp_err   <= ~cmd_legal;
          state       <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rdata        = rdata_q;
  assign o_bank_addr    = cmd_addr;
  assign o_bank_st_data = cmd_wdata;
  assign o_bank_funct3  = cmd_funct3;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// tb_io_bank_arbiter: directed and randomized stimulus; a reference model predicts
// grants, strobes and responses, a monitor pops the expected-response queue.
module tb_io_bank_arbiter;
  import io_arb_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7000;

  logic        i_clk;
  logic        i_rst;
  logic [1:0]  i_req;
  logic [1:0]  i_wren;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [5:0]  i_funct3;
  logic [1:0]  o_gnt;
  logic [1:0]  o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rdata;
  logic        o_bank_wren;
  logic        o_bank_rden;
  logic        o_bank_buf_en;
  logic [31:0] o_bank_addr;
  logic [31:0] o_bank_st_data;
  logic [2:0]  o_bank_funct3;
  logic [31:0] i_bank_ld_data;

  io_bank_arbiter #(.BASE_ADDR(BASE)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_wren         (i_wren),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .i_funct3       (i_funct3),
    .o_gnt          (o_gnt),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_err      (o_rsp_err),
    .o_rdata        (o_rdata),
    .o_bank_wren    (o_bank_wren),
    .o_bank_rden    (o_bank_rden),
    .o_bank_buf_en  (o_bank_buf_en),
    .o_bank_addr    (o_bank_addr),
    .o_bank_st_data (o_bank_st_data),
    .o_bank_funct3  (o_bank_funct3),
    .i_bank_ld_data (i_bank_ld_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-granular bank model; an override forces a fixed load value.
  logic [31:0] bank_mem [16] = '{default: 32'h0};
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  assign i_bank_ld_data = ovr_en ? ovr_data : bank_mem[o_bank_addr[5:2]];
  always @(posedge i_clk) if (o_bank_wren) bank_mem[o_bank_addr[5:2]] <= o_bank_st_data;

  // Reference model state.
  typedef struct {
    int          owner;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  bit          acc_v = 1'b0;
  int          acc_owner;
  bit          acc_wr;
  bit          acc_legal;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_f3;
`ifdef IO_ARB_RR_EN
  int          rr_last = 1;
`endif

  function automatic bit ref_legal(input bit wr, input logic [31:0] a, input logic [2:0] f);
    int size;
    if (a < BASE || a >= BASE + 32'd64) return 1'b0;
    case (f)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    return 1'b0;
    endcase
    if (wr && f > 3'd2) return 1'b0;
    return (a % size) == 0;
  endfunction

  always @(negedge i_clk) begin
    logic [1:0]  exp_gnt;
    int          w;
    logic [31:0] rd;
    rsp_t        it;
    if (i_rst) begin
      check("rst_gnt", 32'(o_gnt), 32'h0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
      check("rst_rsp_err", 32'(o_rsp_err), 32'h0);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_strobes", 32'({o_bank_buf_en, o_bank_wren, o_bank_rden}), 32'h0);
      check("rst_bank_addr", o_bank_addr, 32'h0);
      check("rst_bank_data", o_bank_st_data, 32'h0);
      check("rst_bank_f3", 32'(o_bank_funct3), 32'h0);
      acc_v = 1'b0;
      exp_q.delete();
`ifdef IO_ARB_RR_EN
      rr_last = 1;
`endif
    end else begin
      if (acc_v) begin
        check("acc_strobes", 32'({o_bank_buf_en, o_bank_wren, o_bank_rden}),
              32'({acc_legal, acc_legal & acc_wr, acc_legal & !acc_wr}));
        check("acc_addr", o_bank_addr, acc_addr);
        check("acc_data", o_bank_st_data, acc_wdata);
        check("acc_f3", 32'(o_bank_funct3), 32'(acc_f3));
        rd = 32'h0;
        if (acc_legal && acc_wr) ref_mem[acc_addr[5:2]] = acc_wdata;
        if (acc_legal && !acc_wr) rd = ovr_en ? ovr_data : ref_mem[acc_addr[5:2]];
        it = '{owner: acc_owner, err: !acc_legal, rdata: rd, due: cyc + 1};
        exp_q.push_back(it);
      end else begin
        check("idle_strobes", 32'({o_bank_buf_en, o_bank_wren, o_bank_rden}), 32'h0);
      end
      exp_gnt = 2'b00;
      w = 0;
      if (!acc_v && i_req != 2'b00) begin
        if (i_req == 2'b11) begin
`ifdef IO_ARB_RR_EN
          w = 1 - rr_last;
`else
          w = 0;
`endif
        end else begin
          w = i_req[1] ? 1 : 0;
        end
        exp_gnt = (w == 1) ? 2'b10 : 2'b01;
      end
      check("gnt", 32'(o_gnt), 32'(exp_gnt));
      acc_v = (exp_gnt != 2'b00);
      if (acc_v) begin
        acc_owner = w;
        acc_wr    = i_wren[w];
        acc_addr  = i_addr[w*32 +: 32];
        acc_wdata = i_wdata[w*32 +: 32];
        acc_f3    = i_funct3[w*3 +: 3];
        acc_legal = ref_legal(acc_wr, acc_addr, acc_f3);
`ifdef IO_ARB_RR_EN
        rr_last = w;
`endif
      end
    end
  end

  // Response monitor.
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  int          strobe_cnt = 0;
  always @(negedge i_clk) begin
    rsp_t it;
    if (o_bank_buf_en || o_bank_wren || o_bank_rden) strobe_cnt++;
    if (!i_rst) begin
      if (o_rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(o_rsp_valid), 32'h0);
        end else begin
          it = exp_q.pop_front();
          check("rsp_owner", 32'(o_rsp_valid), (it.owner == 1) ? 32'h2 : 32'h1);
          check("rsp_err", 32'(o_rsp_err), 32'(it.err));
          check("rsp_rdata", o_rdata, it.rdata);
          check("rsp_cycle", cyc, it.due);
        end
        last_rdata = o_rdata;
        last_err   = o_rsp_err;
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("rsp_missing", 32'h0, 32'h1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_fields(input int r, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f);
    i_wren[r]           = wr;
    i_addr[r*32 +: 32]  = a;
    i_wdata[r*32 +: 32] = d;
    i_funct3[r*3 +: 3]  = f;
  endtask

  // Raise a request and hold it until granted; returns just after the grant edge.
  task automatic issue(input int r, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    bit got;
    got = 1'b0;
    set_fields(r, wr, a, d, f);
    i_req[r] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      got = o_gnt[r];
    end
    check("grant_wait", 32'(got), 32'h1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic rand_fields(input int r);
    logic [31:0] a;
    case ($urandom_range(7))
      0:       a = 32'h7040 + $urandom_range(63);
      1:       a = 32'h6FC0 + $urandom_range(63);
      default: a = BASE + $urandom_range(63);
    endcase
    set_fields(r, 1'($urandom_range(1)), a, $urandom, 3'($urandom_range(7)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int g1;
    int s0;
    int t0;
    int t1;
    int t2;
    logic [1:0] g;
    i_rst = 1'b1;
    i_req = 2'b00;
    i_wren = 2'b00;
    i_addr = 64'h0;
    i_wdata = 64'h0;
    i_funct3 = 6'h0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Single write then read back through the bank model.
    issue(0, 1'b1, 32'h7000, 32'hA5A5_1234, SW);
    i_req[0] = 1'b0;
    idle(2);
    issue(0, 1'b0, 32'h7000, 32'h0, LW);
    i_req[0] = 1'b0;
    idle(2);
    check("wr_rd_data", last_rdata, 32'hA5A5_1234);
    check("wr_rd_err", 32'(last_err), 32'h0);

    // Load data is passed through unmodified.
    ovr_en = 1'b1;
    ovr_data = 32'hFFFF_FF80;
    issue(0, 1'b0, 32'h7003, 32'h0, LB);
    i_req[0] = 1'b0;
    idle(2);
    ovr_en = 1'b0;
    check("sext_data", last_rdata, 32'hFFFF_FF80);
    check("sext_err", 32'(last_err), 32'h0);

    // Contention: both requesters hold LW 0x7010.
    set_fields(0, 1'b0, 32'h7010, 32'h0, LW);
    set_fields(1, 1'b0, 32'h7010, 32'h0, LW);
    i_req = 2'b11;
    g0 = 0;
    g1 = 0;
    repeat (12) begin
      @(negedge i_clk);
      g0 += int'(o_gnt[0]);
      g1 += int'(o_gnt[1]);
    end
    @(posedge i_clk);
    #1;
    i_req = 2'b00;
    idle(2);
`ifdef IO_ARB_RR_EN
    check("cont_g0", g0, 3);
    check("cont_g1", g1, 3);
`else
    check("cont_g0", g0, 6);
    check("cont_g1", g1, 0);
`endif

    // Misaligned and out-of-range accesses from requester 1.
    s0 = strobe_cnt;
    issue(1, 1'b0, 32'h7011, 32'h0, LH);
    i_req[1] = 1'b0;
    idle(2);
    check("misal_err", 32'(last_err), 32'h1);
    check("misal_rdata", last_rdata, 32'h0);
    issue(1, 1'b1, 32'h8000, 32'h1111_2222, SW);
    i_req[1] = 1'b0;
    idle(2);
    check("oor_err", 32'(last_err), 32'h1);
    check("oor_rdata", last_rdata, 32'h0);
    check("illegal_strobes", strobe_cnt - s0, 32'h0);

    // Back-to-back byte stores with the request held.
    issue(0, 1'b1, 32'h7020, 32'h0000_00A1, SB);
    t0 = cyc;
    issue(0, 1'b1, 32'h7021, 32'h0000_00B2, SB);
    t1 = cyc;
    issue(0, 1'b1, 32'h7022, 32'h0000_00C3, SB);
    t2 = cyc;
    i_req[0] = 1'b0;
    idle(2);
    check("b2b_gap1", t1 - t0, 32'd2);
    check("b2b_gap2", t2 - t1, 32'd2);

    // Reset during the ACCESS cycle of a store.
    issue(0, 1'b1, 32'h7030, 32'hDEAD_BEEF, SW);
    i_req[0] = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    check("rstmid_rsp_valid", 32'(o_rsp_valid), 32'h0);
    check("rstmid_strobes", 32'({o_bank_buf_en, o_bank_wren, o_bank_rden}), 32'h0);
    check("rstmid_bank_addr", o_bank_addr, 32'h0);
    check("rstmid_rdata", o_rdata, 32'h0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(2);
    check("rstmid_no_write", bank_mem[12], 32'h0);
    set_fields(0, 1'b0, 32'h7010, 32'h0, LW);
    set_fields(1, 1'b0, 32'h7010, 32'h0, LW);
    i_req = 2'b11;
    @(negedge i_clk);
    check("rstmid_first_gnt", 32'(o_gnt), 32'h1);
    @(posedge i_clk);
    #1;
    i_req = 2'b00;
    idle(2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      @(negedge i_clk);
      g = o_gnt;
      @(posedge i_clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        if (g[r] || !i_req[r]) begin
          if ($urandom_range(2) != 0) begin
            rand_fields(r);
            i_req[r] = 1'b1;
          end else begin
            i_req[r] = 1'b0;
          end
        end else if ($urandom_range(15) == 0) begin
          i_req[r] = 1'b0;
        end
      end
    end
    i_req = 2'b00;
    idle(4);
    check("drain", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
